// File: rtl/muldiv_pkg.sv
// Shared types and constants for the M-extension divide control path.
//   XLEN        : datapath width
//   div_op_e    : funct3[1:0] encoding of DIV/DIVU/REM/REMU
//   div_state_e : divide controller states
//   div_key_t   : operand key stored in / compared against the result cache
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            sgn;
    } div_key_t;

    // Two's-complement magnitude; INT_MIN maps to itself, which is its correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// Single-entry divide result cache.
//   clk, reset      : clock, synchronous active-high reset
//   wr_en, wr_key,
//   wr_q, wr_r      : store the signed-corrected results of a finished divide
//   inv             : drop the entry (takes priority over a write)
//   lk_key          : operands of the request being classified
//   hit_c           : combinational hit for lk_key
//   hit_q, hit_r    : stored quotient / remainder
module div_result_cache
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  div_key_t        wr_key,
    input  logic [XLEN-1:0] wr_q,
    input  logic [XLEN-1:0] wr_r,
    input  logic            inv,
    input  div_key_t        lk_key,
    output logic            hit_c,
    output logic [XLEN-1:0] hit_q,
    output logic [XLEN-1:0] hit_r
);

    logic     valid;
    div_key_t key;

    // Entry storage
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            key   <= '0;
            hit_q <= '0;
            hit_r <= '0;
        end else if (inv) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid <= 1'b1;
            key   <= wr_key;
            hit_q <= wr_q;
            hit_r <= wr_r;
        end
    end

    // Signedness is part of the key so DIV/REM share an entry but DIVU does not.
    assign hit_c = valid && (key == lk_key);

endmodule

// File: rtl/div_ctrl.sv
// EX-stage divide controller: classifies DIV/DIVU/REM/REMU requests, serves
// divide-by-zero, signed overflow and cached results in one cycle, otherwise
// runs an external unsigned sequential divider on operand magnitudes and
// applies the sign correction.
//   clk, reset                  : clock, synchronous active-high reset
//   req_valid, req_op,
//   req_a, req_b                : request and operands (held while stall)
//   flush                       : kill the current instruction
//   stall                       : freeze pipeline front end
//   rsp_valid, rsp_data         : one-cycle result pulse and rd value
//   div_enable, div_sign_sel,
//   div_numA, div_denB          : divider start level and unsigned operands
//   div_done, div_quotient,
//   div_remainder               : divider completion and unsigned results
module div_ctrl
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            div_enable,
    output logic            div_sign_sel,
    output logic [XLEN-1:0] div_numA,
    output logic [XLEN-1:0] div_denB,
    input  logic            div_done,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);

    div_state_e      state, state_nxt;

    logic            req_sgn, req_zero, req_ovf, special, accept;
    logic            cache_hit, capture, invalidate, is_rem;
    logic [XLEN-1:0] sp_q, sp_r, hit_q, hit_r, q_fix, r_fix;
    div_key_t        lk_key, wr_key;

    logic [XLEN-1:0] a_q, b_q, num_a_q, den_b_q, q_res, r_res;
    div_op_e         op_q;
    logic            sgn_q;

    // Request classification
    assign req_sgn  = ~req_op[0];
    assign req_zero = (req_b == '0);
    assign req_ovf  = req_sgn && (req_a == INT_MIN) && (req_b == DIV_ZERO_Q);
    assign special  = req_zero || req_ovf;
    assign sp_q     = req_zero ? DIV_ZERO_Q : INT_MIN;
    assign sp_r     = req_zero ? req_a : '0;
    assign accept   = (state == ST_IDLE) && req_valid && !flush;

    assign lk_key   = '{a: req_a, b: req_b, sgn: req_sgn};
    assign wr_key   = '{a: a_q, b: b_q, sgn: sgn_q};

    // Sign correction of the unsigned divider results
    assign q_fix  = (sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_quotient  : div_quotient;
    assign r_fix  = (sgn_q && a_q[XLEN-1])                 ? -div_remainder : div_remainder;
    assign is_rem = (op_q == OP_REM) || (op_q == OP_REMU);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control outputs
    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        div_enable = 1'b0;
        capture    = 1'b0;
        invalidate = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = req_valid;
                if (accept) begin
                    state_nxt = (special || cache_hit) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall      = req_valid;
                div_enable = ~div_done;
                // flush wins over a coincident div_done; the divider is then already idle
                if (flush) begin
                    invalidate = 1'b1;
                    state_nxt  = div_done ? ST_IDLE : ST_DRAIN;
                end else if (div_done) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DRAIN: begin
                stall = req_valid;
                if (div_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                rsp_valid = ~flush;
                rsp_data  = flush ? '0 : (is_rem ? r_res : q_res);
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_DIV;
            sgn_q   <= 1'b0;
            num_a_q <= '0;
            den_b_q <= '0;
            q_res   <= '0;
            r_res   <= '0;
        end else begin
            if (accept) begin
                a_q     <= req_a;
                b_q     <= req_b;
                op_q    <= div_op_e'(req_op);
                sgn_q   <= req_sgn;
                num_a_q <= req_sgn ? mag(req_a) : req_a;
                den_b_q <= req_sgn ? mag(req_b) : req_b;
                if (special) begin
                    q_res <= sp_q;
                    r_res <= sp_r;
                end else if (cache_hit) begin
                    q_res <= hit_q;
                    r_res <= hit_r;
                end
            end
            if (capture) begin
                q_res <= q_fix;
                r_res <= r_fix;
            end
        end
    end

    assign div_sign_sel = 1'b1;
    assign div_numA     = num_a_q;
    assign div_denB     = den_b_q;

    div_result_cache u_cache (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (capture),
        .wr_key (wr_key),
        .wr_q   (q_fix),
        .wr_r   (r_fix),
        .inv    (invalidate),
        .lk_key (lk_key),
        .hit_c  (cache_hit),
        .hit_q  (hit_q),
        .hit_r  (hit_r)
    );

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have the following ports, one per line, as name  direction  width  meaning:
REQ-002 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  EX-stage DIV/DIVU/REM/REMU present; held with stable operands while stall=1.
REQ-005 req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-006 req_a / req_b  in  32 each  rs1 (dividend) / rs2 (divisor).
REQ-007 flush  in  1  kill current instruction.
REQ-008 stall  out  1  freeze pipeline front end.
REQ-009 rsp_valid / rsp_data  out  1 / 32  one-cycle result pulse and rd value.
REQ-010 div_enable  out  1  level start to the sequential divider, held until div_done.
REQ-011 div_sign_sel  out  1  constant 1; the divider always runs unsigned.
REQ-012 div_numA / div_denB  out  32 each  dividend / divisor magnitudes from registers.
REQ-013 div_done, div_quotient, div_remainder  in  1, 32, 32  divider completion pulse and unsigned results.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, BUSY, DRAIN, DONE.
REQ-015 In IDLE with req_valid=1 and flush=0, SHALL latch a, b, op and classify the request as special, cache hit or normal.
REQ-016 Special request: b==0, giving q=FFFFFFFF, r=a. Signed overflow (a=80000000, b=FFFFFFFF, signed op) gives q=80000000, r=0.
REQ-017 Special and cache-hit requests SHALL go to DONE next cycle (latency 1), with div_enable never asserted.
REQ-018 Normal requests SHALL go to BUSY and drive div_numA=|a|, div_denB=|b|; magnitudes are used only for signed ops, raw values otherwise.
REQ-019 div_enable SHALL equal (state==BUSY) & ~div_done, so it drops in the cycle div_done is seen.
REQ-020 On div_done in BUSY, SHALL capture results and go to DONE.
REQ-021 Signed ops: q SHALL be negated iff a[31]^b[31]; r SHALL be negated iff a[31].
REQ-022 Unsigned ops SHALL pass results through unchanged.
REQ-023 Normal latency with a 32-iteration divider: request first seen in IDLE at cycle 0, rsp_valid at cycle 35.
REQ-024 stall SHALL equal req_valid & (state!=DONE). In DONE, rsp_valid=1 and rsp_data is q for DIV/DIVU or r for REM/REMU.
REQ-025 DONE SHALL always return to IDLE next cycle; a back-to-back request is accepted in that IDLE cycle.
REQ-026 Result cache: one entry holding a, b, signedness, q and r, written on every normal completion.
REQ-027 A cache hit requires a valid entry plus matching a, b and op[0], so DIV followed by REM on the same operands takes 1 cycle.
REQ-028 flush in IDLE SHALL ignore the request.
REQ-029 flush in DONE SHALL suppress rsp_valid and go to IDLE.
REQ-030 flush in BUSY SHALL drop div_enable, go to DRAIN and invalidate the cache.
REQ-031 DRAIN SHALL wait for div_done, discard the result, then go to IDLE; stall stays high for any req_valid during DRAIN.
REQ-032 flush has priority over div_done in the same cycle: the state goes to DRAIN-exit (IDLE) and no rsp_valid is produced.

Reset
REQ-033 On reset: state=IDLE, cache invalid, stall=0, rsp_valid=0, rsp_data=0, div_enable=0, all operand and result registers 0.
REQ-034 A reset mid-BUSY SHALL abandon the operation; the divider is reset by the same signal.

Structure
REQ-035 Package muldiv_pkg SHALL hold the req_op encoding enum, the FSM state enum, XLEN=32, and the DIV_ZERO_Q/INT_MIN constants.
REQ-036 The cache SHALL be a sub-module div_result_cache (write, lookup, invalidate); the divider is instantiated at the EX-stage level, not inside this block.

Verification
REQ-037 DIV 7 / FFFFFFFE -> rsp_data FFFFFFFD at cycle 35; then REM with the same operands -> 00000001 after 1 cycle (cache hit).
REQ-038 DIVU 100 / 7 -> 0000000E at cycle 35; REMU 100 / 7 (new b first, so a miss) -> 00000002.
REQ-039 DIV 5 / 0 -> FFFFFFFF, and REM 5 / 0 -> 00000005, each in 1 cycle with div_enable low throughout.
REQ-040 DIV 80000000 / FFFFFFFF -> 80000000, and REM -> 0, each in 1 cycle.
REQ-041 DIV FFFFFFF9 / 2 -> FFFFFFFD, and REM -> FFFFFFFF (remainder follows dividend sign).
REQ-042 flush at cycle 10 of DIVU 1000/3 -> no rsp_valid; a next DIVU 9/3 stalls through DRAIN and returns 00000003 with no cache hit.
